// File: rtl/pipo_arb_pkg.sv
// Shared types, default sizes and width helper for the PIPO write arbiter.
package pipo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 4;
  localparam int DEF_HOLD_CYCLES = 2;

  // Index width for a value range of n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/pipo_write_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr wins.
module rr_pick
  import pipo_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = idx_w(DEF_NUM_REQ)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand_s;

  // Walk the request vector from ptr upwards, wrapping at N.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = 0;
    for (int k = 0; k < N; k++) begin
      cand_s = (int'(ptr) + k) % N;
      if (!any && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        idx         = IW'(cand_s);
        any         = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/pipo_write_arbiter.sv
// Round-robin arbiter owning a shared PIPO holding register with post-load hold.
// Optional requester lock when PIPO_ARB_LOCK_EN is defined.
module pipo_write_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
`ifdef PIPO_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]          req_lock,
`endif
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           data_out,
  output logic                        load_pulse,
  output logic [idx_w(NUM_REQ)-1:0]   grant_id,
  output logic                        busy
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  arb_state_t          state_r;
  arb_state_t          state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    rr_ptr_r;
  logic [IDX_W-1:0]    next_ptr_s;
  logic [DATA_W-1:0]   data_out_r;
  logic [IDX_W-1:0]    grant_id_r;
  logic                load_pulse_r;
  logic                busy_r;
  logic [NUM_REQ-1:0]  pick_req_s;
  logic [NUM_REQ-1:0]  pick_gnt_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;
  logic [NUM_REQ-1:0]  ready_s;
  logic                transfer_s;
  logic                win_lock_s;
  logic [DATA_W-1:0]   win_data_s;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req (pick_req_s),
    .ptr (rr_ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

`ifdef PIPO_ARB_LOCK_EN
  logic               lock_valid_r;
  logic [IDX_W-1:0]   lock_owner_r;
  logic [NUM_REQ-1:0] lock_mask_s;

  // While locked, only the owner's request is visible to the picker.
  always_comb begin
    lock_mask_s = {NUM_REQ{1'b1}};
    if (lock_valid_r) begin
      lock_mask_s               = '0;
      lock_mask_s[lock_owner_r] = 1'b1;
    end else begin
      lock_mask_s = {NUM_REQ{1'b1}};
    end
  end

  assign pick_req_s = req_valid & lock_mask_s;
  assign win_lock_s = req_lock[pick_idx_s];

  // Lock is (re)evaluated on every transfer from the winner's lock request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_valid_r <= 1'b0;
      lock_owner_r <= '0;
    end else if (transfer_s) begin
      lock_valid_r <= win_lock_s;
      lock_owner_r <= pick_idx_s;
    end else begin
      lock_valid_r <= lock_valid_r;
      lock_owner_r <= lock_owner_r;
    end
  end
`else
  assign pick_req_s = req_valid;
  assign win_lock_s = 1'b0;
`endif

  assign win_data_s = req_data[int'(pick_idx_s)*DATA_W +: DATA_W];
  assign next_ptr_s = (pick_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_s + IDX_W'(1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a zero hold keeps the arbiter in IDLE permanently.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (transfer_s && (HOLD_CYCLES > 0)) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt_r == '0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: ready only from IDLE and never while reset is asserted.
  always_comb begin
    ready_s    = '0;
    transfer_s = 1'b0;
    if ((state_r == ST_IDLE) && !reset) begin
      ready_s    = pick_gnt_s;
      transfer_s = pick_any_s;
    end else begin
      ready_s    = '0;
      transfer_s = 1'b0;
    end
  end

  // Holding register, grant bookkeeping, hold counter and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_r   <= '0;
      grant_id_r   <= '0;
      rr_ptr_r     <= '0;
      load_pulse_r <= 1'b0;
      cnt_r        <= '0;
      busy_r       <= 1'b0;
    end else begin
      load_pulse_r <= transfer_s;
      busy_r       <= (state_nxt_s == ST_HOLD);
      if (transfer_s) begin
        data_out_r <= win_data_s;
        grant_id_r <= pick_idx_s;
        cnt_r      <= HOLD_LOAD;
        if (!win_lock_s) begin
          rr_ptr_r <= next_ptr_s;
        end else begin
          rr_ptr_r <= rr_ptr_r;
        end
      end else if ((state_r == ST_HOLD) && (cnt_r != '0)) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign req_ready  = ready_s;
  assign data_out   = data_out_r;
  assign grant_id   = grant_id_r;
  assign load_pulse = load_pulse_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// Scoreboard bench for pipo_write_arbiter: one instance with HOLD_CYCLES=2, one with 0.
module tb_pipo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   valid [2];
  logic [N*W-1:0] data  [2];
  logic [N-1:0]   lock  [2];
  logic [N-1:0]   ready [2];
  logic [W-1:0]   dout  [2];
  logic           lp    [2];
  logic [IW-1:0]  gid   [2];
  logic           bsy   [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int           id;
    logic [W-1:0] d;
  } exp_t;

  logic [W:0] rq [2][N][$];   // per-requester word queues, bit W = lock request
  exp_t       sb [2][$];

  int           hold_c [2] = '{2, 0};
  int           m_ptr  [2];
  int           m_last [2];
  int           m_own  [2];
  bit           m_lk   [2];
  logic [W-1:0] m_dout [2];

  pipo_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_CYCLES(2)) dut_h2 (
    .clk(clk), .reset(reset), .req_valid(valid[0]), .req_data(data[0]),
`ifdef PIPO_ARB_LOCK_EN
    .req_lock(lock[0]),
`endif
    .req_ready(ready[0]), .data_out(dout[0]), .load_pulse(lp[0]),
    .grant_id(gid[0]), .busy(bsy[0])
  );

  pipo_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_CYCLES(0)) dut_h0 (
    .clk(clk), .reset(reset), .req_valid(valid[1]), .req_data(data[1]),
`ifdef PIPO_ARB_LOCK_EN
    .req_lock(lock[1]),
`endif
    .req_ready(ready[1]), .data_out(dout[1]), .load_pulse(lp[1]),
    .grant_id(gid[1]), .busy(bsy[1])
  );

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d cycle=%0d actual=%0d expected=%0d", nm, k, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k]  = 0;
      m_last[k] = -100;
      m_lk[k]   = 1'b0;
      m_own[k]  = 0;
      m_dout[k] = '0;
    end
  endtask

  task automatic push(input int i, input logic [W:0] w);
    for (int k = 0; k < 2; k++) rq[k][i].push_back(w);
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[k][i].size() > 0) begin
          valid[k][i]       = 1'b1;
          data[k][i*W +: W] = rq[k][i][0][W-1:0];
          lock[k][i]        = rq[k][i][0][W];
        end else begin
          valid[k][i]       = 1'b0;
          data[k][i*W +: W] = W'($urandom);
          lock[k][i]        = 1'b0;
        end
      end
    end
  endtask

  // Reference: grants allowed once the hold window since the last grant has elapsed;
  // the first valid requester at or after the pointer (or only the lock owner) wins.
  task automatic step(input int k);
    int win;
    int i;
    logic [W:0] w;
    exp_t e;
    chk("load_pulse", k, int'(lp[k]), int'(m_last[k] == cyc - 1));
    chk("busy", k, int'(bsy[k]), int'((cyc > m_last[k]) && (cyc <= m_last[k] + hold_c[k])));
    chk("data_out", k, int'(dout[k]), int'(m_dout[k]));
    win = -1;
    if (cyc >= m_last[k] + 1 + hold_c[k]) begin
      for (int off = 0; off < N; off++) begin
        i = (m_ptr[k] + off) % N;
        if (win < 0 && valid[k][i] && (!m_lk[k] || i == m_own[k])) win = i;
      end
    end
    chk("req_ready", k, int'(ready[k]), (win >= 0) ? (1 << win) : 0);
    if (win >= 0) begin
      w    = rq[k][win].pop_front();
      e.id = win;
      e.d  = w[W-1:0];
      sb[k].push_back(e);
      m_dout[k] = w[W-1:0];
      m_last[k] = cyc;
      if (w[W]) begin
        m_lk[k]  = 1'b1;
        m_own[k] = win;
      end else begin
        m_lk[k]  = 1'b0;
        m_ptr[k] = (win + 1) % N;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      drive_inputs();
      #1;
      for (int k = 0; k < 2; k++) step(k);
    end
  endtask

  task automatic drain();
    int guard;
    int pending;
    guard = 0;
    pending = 1;
    while (pending != 0 && guard < 300) begin
      run_cycles(1);
      guard++;
      pending = 0;
      for (int k = 0; k < 2; k++) begin
        pending += sb[k].size();
        for (int i = 0; i < N; i++) pending += rq[k][i].size();
      end
    end
    chk("drain_pending", 0, pending, 0);
  endtask

  // Monitor: every load pulse must match the oldest expected grant.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (lp[k] === 1'b1) begin
          chk("sb_nonempty", k, int'(sb[k].size() > 0), 1);
          if (sb[k].size() > 0) begin
            e = sb[k].pop_front();
            chk("sb_data", k, int'(dout[k]), int'(e.d));
            chk("sb_grant", k, int'(gid[k]), e.id);
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      valid[k] = '1;
      data[k]  = '1;
      lock[k]  = '0;
    end
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_data_out", k, int'(dout[k]), 0);
      chk("rst_load_pulse", k, int'(lp[k]), 0);
      chk("rst_busy", k, int'(bsy[k]), 0);
      chk("rst_grant_id", k, int'(gid[k]), 0);
      chk("rst_ready", k, int'(ready[k]), 0);
    end
    @(negedge clk);
    drive_inputs();
    @(negedge clk);
    reset = 1'b0;

    // Lone requester 1, then quiet period.
    push(1, {1'b0, 4'h9});
    run_cycles(6);
    run_cycles(10);

    // Reset in the middle of a hold with data_out = A.
    push(3, {1'b0, 4'hA});
    run_cycles(1);
    @(posedge clk);
    #2;
    chk("pre_rst_data_out", 0, int'(dout[0]), 4'hA);
    chk("pre_rst_busy", 0, int'(bsy[0]), 1);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_data_out", k, int'(dout[k]), 0);
      chk("midrst_busy", k, int'(bsy[k]), 0);
      chk("midrst_load_pulse", k, int'(lp[k]), 0);
      chk("midrst_ready", k, int'(ready[k]), 0);
    end
    model_reset();
    @(negedge clk);
    drive_inputs();
    @(negedge clk);
    reset = 1'b0;

    // All four continuously requesting; first grant after reset goes to req0.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, {1'b0, 4'(i + 1)});
    run_cycles(26);

    // Two contenders: back-to-back alternation on the zero-hold instance.
    for (int r = 0; r < 3; r++) begin
      push(2, {1'b0, 4'(4'h5 + r)});
      push(3, {1'b0, 4'(4'hC + r)});
    end
    run_cycles(20);
    drain();
    run_cycles(10);

    // Randomized traffic.
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if (rq[0][i].size() < 3 && $urandom_range(0, 3) == 0) push(i, {1'b0, 4'($urandom)});
      run_cycles(1);
    end
    drain();

`ifdef PIPO_ARB_LOCK_EN
    // Req0 locks twice, req1 must starve until the unlocking transfer.
    push(0, {1'b1, 4'h5});
    push(0, {1'b1, 4'h6});
    push(0, {1'b0, 4'h7});
    run_cycles(1);
    push(1, {1'b0, 4'h8});
    run_cycles(20);
    drain();
`endif

    run_cycles(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
